// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target (i2c_slave_stream).
package i2c_pkg;

    localparam int         I2C_BYTE_WIDTH    = 8;
    localparam logic [6:0] I2C_GEN_CALL_ADDR = 7'h00;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_RX_DATA   = 3'd3,
        ST_RX_ACK    = 3'd4,
        ST_TX_DATA   = 3'd5,
        ST_TX_ACK    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } fsm_state_t;

    // Masked address compare: a set mask bit makes that address bit a don't-care.
    function automatic logic addr_match(input logic [6:0] rx_addr,
                                        input logic [6:0] own_addr,
                                        input logic [6:0] mask);
        return ((rx_addr ^ own_addr) & ~mask) == 7'd0;
    endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Pad-line conditioner: two-flop synchroniser, then a level filter that only
// follows the line once it has been stable for DEPTH consecutive samples.
// rise_o/fall_o are single-cycle strobes coincident with the level_o change.
module i2c_line_filter
#(
    parameter int DEPTH = 3
)
(
    input  logic clk_i,
    input  logic a_rst_n_i,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0]       sync_q;
    logic [DEPTH-1:0] hist_q;

    // Synchronise, collect history and update the filtered level with edge strobes.
    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            // Idle bus level is high, so everything resets to 1 to avoid a phantom edge.
            sync_q  <= 2'b11;
            hist_q  <= '1;
            level_o <= 1'b1;
            rise_o  <= 1'b0;
            fall_o  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every stage sample the previous
            // value of the one before it, which is what makes this a shift chain.
            sync_q <= {sync_q[0], line_i};
            hist_q <= {hist_q[DEPTH-2:0], sync_q[1]};
            rise_o <= 1'b0;
            fall_o <= 1'b0;
            if (&hist_q && !level_o) begin
                level_o <= 1'b1;
                rise_o  <= 1'b1;
            end else if (~|hist_q && level_o) begin
                level_o <= 1'b0;
                fall_o  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_slave_stream.sv
// I2C target with masked 7-bit address match, general call, and valid/ready
// byte streams for received (m_*) and transmitted (s_*) data.
// Build option: define I2C_SLAVE_STRETCH_EN to stretch SCL on RX overflow /
// TX underrun instead of NACKing / sending 0xFF.
module i2c_slave_stream
    import i2c_pkg::*;
#(
    parameter int FILTER_DEPTH = 3,
    parameter int ADDR_WIDTH   = 7
)
(
    input  logic                      clk_i,
    input  logic                      a_rst_n_i,
    input  logic                      en_i,
    input  logic [ADDR_WIDTH-1:0]     own_addr_i,
    input  logic [ADDR_WIDTH-1:0]     addr_mask_i,
    input  logic                      gen_call_en_i,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      scl_o,
    output logic                      sda_o,
    output logic                      scl_t,
    output logic                      sda_t,
    output logic [I2C_BYTE_WIDTH-1:0] m_data_o,
    output logic                      m_valid_o,
    input  logic                      m_ready_i,
    output logic                      m_first_o,
    input  logic [I2C_BYTE_WIDTH-1:0] s_data_i,
    input  logic                      s_valid_i,
    output logic                      s_ready_o,
    output logic                      busy_o,
    output logic                      gen_call_o,
    output logic                      stop_o,
    output logic                      nack_o,
    output logic                      ovf_o,
    output logic                      unf_o
);

    localparam logic [3:0] LAST_BIT = 4'(I2C_BYTE_WIDTH);

    logic scl, sda, scl_rise, scl_fall, sda_rise, sda_fall;

    i2c_line_filter #(.DEPTH(FILTER_DEPTH)) u_scl_filter (
        .clk_i(clk_i), .a_rst_n_i(a_rst_n_i), .line_i(scl_i),
        .level_o(scl), .rise_o(scl_rise), .fall_o(scl_fall)
    );

    i2c_line_filter #(.DEPTH(FILTER_DEPTH)) u_sda_filter (
        .clk_i(clk_i), .a_rst_n_i(a_rst_n_i), .line_i(sda_i),
        .level_o(sda), .rise_o(sda_rise), .fall_o(sda_fall)
    );

    fsm_state_t                state_q;
    logic [3:0]                bit_cnt_q;
    logic [I2C_BYTE_WIDTH-1:0] sh_q;      // address / RX shifter
    logic [I2C_BYTE_WIDTH-1:0] tx_q;      // TX shifter, MSB is the next bit out
    logic [6:0]                own_q;     // own address captured at START
    logic rw_q, first_q, busy_q, gc_q, sda_t_q;
    logic stop_q, nack_q, ovf_q, unf_q;

    logic start_evt, stop_evt, line_evt, addr_hit, gc_hit, rx_space;
    logic tx_slot, rx_slot, tx_retry, rx_retry, tx_load, rx_load;

    assign start_evt = sda_fall & scl;
    assign stop_evt  = sda_rise & scl;
    assign line_evt  = start_evt | stop_evt;
    assign addr_hit  = addr_match(sh_q[7:1], own_q, addr_mask_i);
    assign gc_hit    = gen_call_en_i && (sh_q[7:1] == I2C_GEN_CALL_ADDR) && !sh_q[0];
    assign rx_space  = !m_valid_o || m_ready_i;

    // A TX byte is fetched on the SCL fall that ends the address ACK or a master ACK.
    assign tx_slot = en_i && !line_evt && scl_fall &&
                     ((state_q == ST_ADDR_ACK && rw_q) || state_q == ST_TX_ACK);
    assign rx_slot = en_i && !line_evt && scl_fall &&
                     state_q == ST_RX_DATA && bit_cnt_q == LAST_BIT;

`ifdef I2C_SLAVE_STRETCH_EN
    logic stall_q;  // SCL held low while waiting for stream space/data
    assign tx_retry = en_i && !line_evt && stall_q && state_q == ST_TX_DATA;
    assign rx_retry = en_i && !line_evt && stall_q && state_q == ST_RX_DATA;
    assign scl_t    = !stall_q;
`else
    assign tx_retry = 1'b0;
    assign rx_retry = 1'b0;
    assign scl_t    = 1'b1;
`endif

    assign tx_load   = tx_slot | tx_retry;
    assign rx_load   = rx_slot | rx_retry;
    assign s_ready_o = tx_load;

    assign scl_o      = 1'b0;
    assign sda_o      = 1'b0;
    assign sda_t      = sda_t_q;
    assign busy_o     = busy_q;
    assign gen_call_o = gc_q;
    assign stop_o     = stop_q;
    assign nack_o     = nack_q;
    assign ovf_o      = ovf_q;
    assign unf_o      = unf_q;

    // Protocol FSM: bus conditions first, then per-state bit handling, then byte hand-offs.
    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            sh_q      <= '0;
            tx_q      <= '0;
            own_q     <= '0;
            rw_q      <= 1'b0;
            first_q   <= 1'b0;
            busy_q    <= 1'b0;
            gc_q      <= 1'b0;
            sda_t_q   <= 1'b1;
            stop_q    <= 1'b0;
            nack_q    <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
            stall_q   <= 1'b0;
`endif
        end else begin
            stop_q <= 1'b0;
            nack_q <= 1'b0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            if (!en_i || line_evt) begin
                // Disable, START and STOP all release the bus and end any transfer.
                sda_t_q <= 1'b1;
                busy_q  <= 1'b0;
                gc_q    <= 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
                stall_q <= 1'b0;
`endif
                if (!en_i) begin
                    state_q <= ST_IDLE;
                end else if (start_evt) begin
                    state_q   <= ST_ADDR;
                    bit_cnt_q <= '0;
                    own_q     <= 7'(own_addr_i);
                end else begin
                    state_q <= ST_IDLE;
                    stop_q  <= busy_q;
                end
            end else begin
                case (state_q)
                    ST_ADDR, ST_RX_DATA: begin
                        if (scl_rise && bit_cnt_q != LAST_BIT) begin
                            sh_q      <= {sh_q[I2C_BYTE_WIDTH-2:0], sda};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                        if (state_q == ST_ADDR && scl_fall && bit_cnt_q == LAST_BIT) begin
                            if (addr_hit || gc_hit) begin
                                state_q <= ST_ADDR_ACK;
                                sda_t_q <= 1'b0;
                                busy_q  <= 1'b1;
                                gc_q    <= gc_hit;
                                rw_q    <= sh_q[0];
                            end else begin
                                state_q <= ST_WAIT_STOP;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall && !rw_q) begin
                            state_q   <= ST_RX_DATA;
                            sda_t_q   <= 1'b1;
                            bit_cnt_q <= '0;
                            first_q   <= 1'b1;
                        end
                    end
                    ST_RX_ACK: begin
                        if (scl_fall) begin
                            state_q   <= ST_RX_DATA;
                            sda_t_q   <= 1'b1;
                            bit_cnt_q <= '0;
                        end
                    end
                    ST_TX_DATA: begin
                        if (scl_rise && bit_cnt_q != LAST_BIT) begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                        if (scl_fall) begin
                            if (bit_cnt_q == LAST_BIT) begin
                                state_q <= ST_TX_ACK;
                                sda_t_q <= 1'b1;
                            end else begin
                                sda_t_q <= tx_q[I2C_BYTE_WIDTH-1];
                                tx_q    <= {tx_q[I2C_BYTE_WIDTH-2:0], 1'b1};
                            end
                        end
                    end
                    ST_TX_ACK: begin
                        if (scl_rise && sda) begin
                            state_q <= ST_WAIT_STOP;
                            nack_q  <= 1'b1;
                        end
                    end
                    default: ;
                endcase

                if (tx_load) begin
                    state_q   <= ST_TX_DATA;
                    bit_cnt_q <= '0;
                    if (s_valid_i) begin
                        tx_q    <= {s_data_i[I2C_BYTE_WIDTH-2:0], 1'b1};
                        sda_t_q <= s_data_i[I2C_BYTE_WIDTH-1];
`ifdef I2C_SLAVE_STRETCH_EN
                        stall_q <= 1'b0;
`endif
                    end else begin
                        sda_t_q <= 1'b1;
`ifdef I2C_SLAVE_STRETCH_EN
                        stall_q <= 1'b1;
`else
                        tx_q    <= '1;
                        unf_q   <= 1'b1;
`endif
                    end
                end

                if (rx_load) begin
                    if (rx_space) begin
                        state_q <= ST_RX_ACK;
                        sda_t_q <= 1'b0;
                        first_q <= 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
                        stall_q <= 1'b0;
`endif
                    end else begin
`ifdef I2C_SLAVE_STRETCH_EN
                        stall_q <= 1'b1;
`else
                        state_q <= ST_WAIT_STOP;
                        sda_t_q <= 1'b1;
                        ovf_q   <= 1'b1;
`endif
                    end
                end
            end
        end
    end

    // RX holding register: loaded when the FSM accepts a byte, drained by m_ready_i.
    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            m_data_o  <= '0;
            m_valid_o <= 1'b0;
            m_first_o <= 1'b0;
        end else if (rx_load && rx_space) begin
            m_data_o  <= sh_q;
            m_valid_o <= 1'b1;
            m_first_o <= first_q;
        end else if (m_ready_i) begin
            m_valid_o <= 1'b0;
            m_first_o <= 1'b0;
        end
    end

endmodule
